// File: rtl/mem_arbiter.sv
// Three-requester (VGA/CPU/PS2) arbiter onto one synchronous single-port RAM; define MEM_ARB_RR_EN for CPU/PS2 round-robin.
// Latency: request sampled in IDLE, memory access next cycle, ack pulse in the third cycle (3-cycle spacing back to back).
// Backpressure: requesters hold req until their ack; requests seen outside IDLE wait, and a held req is never dropped.
module mem_arbiter (
  input  logic        clock,
  input  logic        reset,
  input  logic        vga_req,
  input  logic [15:0] vga_addr,
  output logic        vga_ack,
  output logic [15:0] vga_rdata,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_ack,
  output logic [15:0] cpu_rdata,
  input  logic        ps2_req,
  input  logic        ps2_we,
  input  logic [15:0] ps2_addr,
  input  logic [15:0] ps2_wdata,
  output logic        ps2_ack,
  output logic [15:0] mem_addr,
  output logic        mem_we,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        busy,
  output logic [1:0]  grant_id
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [1:0] ID_NONE = 2'd0;
  localparam logic [1:0] ID_VGA  = 2'd1;
  localparam logic [1:0] ID_CPU  = 2'd2;
  localparam logic [1:0] ID_PS2  = 2'd3;

  state_t      state_q, state_d;
  logic [1:0]  gid_q, gid_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [15:0] vga_rdata_q, vga_rdata_d;
  logic [15:0] cpu_rdata_q, cpu_rdata_d;
  logic [1:0]  win_id;

`ifdef MEM_ARB_RR_EN
  // Set when PS2 should win the next CPU/PS2 tie; reset favours the CPU.
  logic ps2_first_q, ps2_first_d;
`endif

  always_comb begin
    win_id = ID_NONE;
    if (vga_req) begin
      win_id = ID_VGA;
`ifdef MEM_ARB_RR_EN
    end else if (cpu_req && ps2_req) begin
      win_id = ps2_first_q ? ID_PS2 : ID_CPU;
`endif
    end else if (cpu_req) begin
      win_id = ID_CPU;
    end else if (ps2_req) begin
      win_id = ID_PS2;
    end
  end

  always_comb begin
    state_d     = state_q;
    gid_d       = gid_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    vga_rdata_d = vga_rdata_q;
    cpu_rdata_d = cpu_rdata_q;
`ifdef MEM_ARB_RR_EN
    ps2_first_d = ps2_first_q;
`endif
    case (state_q)
      IDLE: begin
        if (win_id != ID_NONE) begin
          gid_d   = win_id;
          state_d = ACCESS;
          case (win_id)
            ID_VGA: begin
              addr_d = vga_addr;
              we_d   = 1'b0;
            end
            ID_CPU: begin
              addr_d  = cpu_addr;
              we_d    = cpu_we;
              wdata_d = cpu_wdata;
            end
            default: begin
              addr_d  = ps2_addr;
              we_d    = ps2_we;
              wdata_d = ps2_wdata;
            end
          endcase
        end
      end
      ACCESS: state_d = DONE;
      DONE: begin
        state_d = IDLE;
        if (!we_q && gid_q == ID_VGA) vga_rdata_d = mem_rdata;
        if (!we_q && gid_q == ID_CPU) cpu_rdata_d = mem_rdata;
`ifdef MEM_ARB_RR_EN
        if (gid_q == ID_CPU) ps2_first_d = 1'b1;
        if (gid_q == ID_PS2) ps2_first_d = 1'b0;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      gid_q       <= ID_NONE;
      addr_q      <= 16'h0000;
      wdata_q     <= 16'h0000;
      we_q        <= 1'b0;
      vga_rdata_q <= 16'h0000;
      cpu_rdata_q <= 16'h0000;
`ifdef MEM_ARB_RR_EN
      ps2_first_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      gid_q       <= gid_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      vga_rdata_q <= vga_rdata_d;
      cpu_rdata_q <= cpu_rdata_d;
`ifdef MEM_ARB_RR_EN
      ps2_first_q <= ps2_first_d;
`endif
    end
  end

  assign busy      = (state_q != IDLE);
  assign grant_id  = (state_q == IDLE) ? ID_NONE : gid_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = (state_q == ACCESS) && we_q;
  assign vga_ack   = (state_q == DONE) && (gid_q == ID_VGA);
  assign cpu_ack   = (state_q == DONE) && (gid_q == ID_CPU);
  assign ps2_ack   = (state_q == DONE) && (gid_q == ID_PS2);

  // RAM data arrives during DONE, so bypass it so rdata is already valid alongside the ack.
  assign vga_rdata = vga_ack ? mem_rdata : vga_rdata_q;
  assign cpu_rdata = (cpu_ack && !we_q) ? mem_rdata : cpu_rdata_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL use one clock and an asynchronous active-low reset, ports named as below:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; 0 = reset
REQ-002 The VGA requester port SHALL be:
- vga_req  in  1  read request, held until vga_ack
- vga_addr  in  16  word address
- vga_ack  out  1  one-cycle pulse, vga_rdata valid
- vga_rdata  out  16  read data, held until next VGA ack
REQ-003 The CPU requester port SHALL be:
- cpu_req  in  1  request, held until cpu_ack
- cpu_we  in  1  1 = write
- cpu_addr  in  16  word address
- cpu_wdata  in  16  write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  16  read data, held until next CPU ack
REQ-004 The PS2 requester port SHALL be ps2_req, ps2_we, ps2_addr[15:0], ps2_wdata[15:0] (in) and ps2_ack (out), with the same meanings as the CPU port; writes only, and the read data is not returned.
REQ-005 The memory side SHALL be:
- mem_addr  out  16  address to the single-port exmem RAM
- mem_we  out  1  write strobe
- mem_wdata  out  16  write data
- mem_rdata  in  16  synchronous read data, valid one cycle after the address
REQ-006 The status outputs SHALL be:
- busy  out  1  high in any state other than IDLE
- grant_id  out  2  current owner: 0 none, 1 VGA, 2 CPU, 3 PS2

Function
REQ-007 The FSM SHALL have exactly three states: IDLE, ACCESS and DONE.
REQ-008 In IDLE, if any request is high, the block SHALL latch the winner's id, address, write enable and write data, then go to ACCESS on the next edge; otherwise it stays in IDLE.
REQ-009 In ACCESS, the block SHALL drive the latched address and data onto the memory port, assert mem_we for exactly this one cycle if the transfer is a write, then go to DONE.
REQ-010 In DONE, the block SHALL:
- capture mem_rdata into the winner's rdata register on a read;
- pulse the winner's ack for exactly one cycle;
- return to IDLE.
REQ-011 Every transaction SHALL take exactly 3 cycles from req being sampled to the ack pulse, and back-to-back transactions SHALL be spaced 3 cycles apart.
REQ-012 Default priority SHALL be fixed: VGA > CPU > PS2.
REQ-013 Requests arriving during ACCESS or DONE SHALL wait for the next IDLE, and a held req is never dropped.
REQ-014 A requester holding req high after its ack SHALL be treated as a new request in the next IDLE.
REQ-015 A VGA request with vga_we absent SHALL always be a read, and mem_we SHALL never be asserted for a VGA transaction.
REQ-016 Outside ACCESS, mem_we SHALL be 0 and mem_addr/mem_wdata SHALL hold their last values.
REQ-017 Changes to a requester's address or data after its req has been sampled SHALL be ignored until the ack.
REQ-018 The address SHALL be passed through unchanged with no wrap or clipping, and all data paths SHALL be 16 bits.

Reset
REQ-019 While reset = 0, asynchronously and regardless of state:
- state = IDLE, grant_id = 0, busy = 0;
- all acks = 0, mem_we = 0;
- mem_addr, mem_wdata, vga_rdata, cpu_rdata = 16'h0000;
- the round-robin pointer points to the CPU.
REQ-020 A transaction interrupted by reset SHALL be abandoned with no ack and no further write; a write aborted in ACCESS MAY have already updated RAM.
REQ-021 The first request SHALL be sampled on the first rising edge after reset returns to 1.

Configuration
REQ-022 When MEM_ARB_RR_EN is defined:
- VGA SHALL remain highest priority;
- CPU and PS2 SHALL alternate, with the one not served most recently winning when both request;
- the pointer SHALL update in DONE only when the CPU or PS2 is served.
REQ-023 When MEM_ARB_RR_EN is undefined, fixed priority VGA > CPU > PS2 SHALL apply and no pointer logic SHALL be present.

Verification
REQ-024 The bench SHALL cover:
- CPU write: cpu_req=1, we=1, addr=16'h007F, wdata=16'h0005 -> mem_we high one cycle with addr 007F, cpu_ack in cycle 3, RAM[127]=0005.
- CPU read: RAM[127]=0005, cpu_req read 007F -> cpu_ack in cycle 3, cpu_rdata=16'h0005, mem_we stays 0.
- VGA, CPU and PS2 requesting in the same cycle -> acks in order VGA, CPU, PS2 at cycles 3, 6 and 9; grant_id sequence 1, 2, 3.
- MEM_ARB_RR_EN defined, CPU and PS2 held high continuously -> acks alternate CPU, PS2, CPU, PS2; without the macro -> CPU only, PS2 starved.
- reset driven to 0 during ACCESS of a CPU read -> busy=0, cpu_ack never pulses, state=IDLE; after reset=1 the held request completes in 3 cycles.
- VGA read of 16'h0000 with vga_addr changed mid-transaction -> data comes from the originally sampled address.
